// File: rtl/alu_mdu_pkg.sv
// Shared constants for the iterative RV M-extension multiply/divide unit:
// funct3 op codes, FSM state type and the step-counter width helper.
package alu_mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step counter must be able to hold the value XLEN itself.
    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

    localparam int XLEN_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = cnt_width(XLEN_DEFAULT);

endpackage

// File: rtl/alu_mdu.sv
// Iterative RV M-extension unit: one shift-add / restoring shift-subtract step per cycle.
// Divide/remainder datapath is built only when MDU_DIV_EN is defined.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

    localparam int            CW        = cnt_width(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0]   opnd;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   res, res_nxt;
    logic              illegal;

    logic              accept, last_step;
    logic              fast, fast_ill, a_sgn, b_sgn, neg_in;
    logic [XLEN-1:0]   fast_res, a_mag, b_mag;
    logic [XLEN:0]     as_a, as_b, as_y;
    logic [2*XLEN-1:0] prod;

`ifdef MDU_DIV_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

    assign in_ready    = (state == ST_IDLE);
    assign accept      = in_valid && in_ready && !kill;
    assign last_step   = (state == ST_BUSY) && (cnt == LAST_STEP);
    assign out_valid   = (state == ST_DONE);
    assign out_result  = out_valid ? res : '0;
    assign out_illegal = out_valid && illegal;

    // Operand decode: signedness, magnitudes, result sign and fast-path detection.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        a_sgn    = 1'b0;
        b_sgn    = 1'b0;
        fast     = 1'b0;
        fast_ill = 1'b0;
        fast_res = '0;
        case (in_funct3)
            F3_MULH: begin
                a_sgn = in_a[XLEN-1];
                b_sgn = in_b[XLEN-1];
            end
            F3_MULHSU: a_sgn = in_a[XLEN-1];
`ifdef MDU_DIV_EN
            F3_DIV, F3_REM: begin
                a_sgn = in_a[XLEN-1];
                b_sgn = in_b[XLEN-1];
            end
`endif
            default: ;
        endcase
`ifdef MDU_DIV_EN
        if (in_funct3[2]) begin
            if (in_b == '0) begin
                fast     = 1'b1;
                fast_res = in_funct3[1] ? in_a : '1;
            end else if (!in_funct3[0] && in_a == MOST_NEG && in_b == '1) begin
                fast     = 1'b1;
                fast_res = in_funct3[1] ? '0 : in_a;
            end
        end
`else
        if (in_funct3[2]) begin
            fast     = 1'b1;
            fast_ill = 1'b1;
        end
`endif
        a_mag  = a_sgn ? -in_a : in_a;
        b_mag  = b_sgn ? -in_b : in_b;
        // Remainder takes the dividend's sign; everything else the product/quotient sign.
        neg_in = (in_funct3 == F3_REM) ? a_sgn : (a_sgn ^ b_sgn);
    end

    // One iteration on the shared {hi, lo} register and XLEN+1 adder/subtractor.
    always_comb begin
        as_b    = {1'b0, opnd};
        as_a    = {1'b0, acc[2*XLEN-1:XLEN]};
        as_y    = as_a + as_b;
        acc_nxt = acc[0] ? {as_y, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
`ifdef MDU_DIV_EN
        if (op[2]) begin
            as_a    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
            as_y    = as_a - as_b;
            acc_nxt = as_y[XLEN] ? {as_a[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {as_y[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
`endif
        prod    = neg ? -acc_nxt : acc_nxt;
        res_nxt = (op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
        if (op[2]) begin
            res_nxt = op[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
            if (neg) res_nxt = -res_nxt;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = fast ? ST_DONE : ST_BUSY;
            ST_BUSY: if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
        if (kill) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so each one samples pre-edge values.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too; the counter and result must read 0 straight out of reset.
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            op      <= F3_MUL;
            neg     <= 1'b0;
            res     <= '0;
            illegal <= 1'b0;
        end else if (kill) begin
            cnt <= '0;
        end else if (accept) begin
            op      <= in_funct3;
            neg     <= neg_in;
            cnt     <= '0;
            illegal <= fast_ill;
            res     <= fast_res;
            acc     <= {{XLEN{1'b0}}, a_mag};
            opnd    <= b_mag;
        end else if (state == ST_BUSY) begin
            acc <= acc_nxt;
            cnt <= last_step ? '0 : cnt + CW'(1);
            if (last_step) res <= res_nxt;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu (XLEN=32): directed corner cases plus random ops
// against an arithmetic reference model; honours MDU_DIV_EN like the RTL.
module tb_alu_mdu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_funct3 = 3'b000;
    logic [XLEN-1:0] in_a = '0;
    logic [XLEN-1:0] in_b = '0;
    logic            kill = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;
    logic            out_illegal;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_a       (in_a),
        .in_b       (in_b),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] res;
        bit          ill;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference model: plain 64-bit arithmetic on the operation's definition.
    task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output bit ill, output int lat);
        longint      sa, sb, p, q;
        logic [63:0] pu;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ill = 1'b0;
        lat = XLEN + 1;
        r   = '0;
        case (f3)
            3'b000: begin pu = {32'b0, a} * {32'b0, b}; r = pu[31:0]; end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
            3'b011: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
            default: begin
`ifdef MDU_DIV_EN
                if (b == 0) begin
                    lat = 1;
                    r   = f3[1] ? a : 32'hFFFF_FFFF;
                end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 1;
                    r   = f3[1] ? 32'h0 : a;
                end else begin
                    case (f3)
                        3'b100:  begin q = sa / sb; r = q[31:0]; end
                        3'b110:  begin q = sa % sb; r = q[31:0]; end
                        3'b101:  r = a / b;
                        default: r = a % b;
                    endcase
                end
`else
                lat = 1;
                ill = 1'b1;
`endif
            end
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: pops one expectation on the first cycle of each result, then
    // checks the result holds until taken and reads zero while not valid.
    initial begin
        exp_t        e;
        bit          seen;
        logic [31:0] held_res;
        bit          held_ill;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                seen = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (!seen) begin
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_out_valid");
                    end else begin
                        e = sb_q.pop_front();
                        check("result", out_result, e.res);
                        check("illegal", 32'(out_illegal), 32'(e.ill));
                        check("latency", cyc - e.acc_cyc + 1, e.lat);
                    end
                    held_res = out_result;
                    held_ill = out_illegal;
                    seen     = 1'b1;
                end else begin
                    check("hold_result", out_result, held_res);
                    check("hold_illegal", 32'(out_illegal), 32'(held_ill));
                end
                if (out_ready) begin
                    seen = 1'b0;
                    done_cnt++;
                end
            end else begin
                seen = 1'b0;
                check("idle_zero", {out_result[30:0], out_illegal}, 32'h0);
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit expect_out, input int hold, input bit use_exp,
                          input logic [31:0] x_res, input bit x_ill, input int x_lat);
        int   n;
        int   d0;
        exp_t e;
        n = 0;
        @(negedge clk);
        #2;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            fail_now("in_ready_timeout");
            return;
        end
        #1;
        d0        = done_cnt;
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_a      = a;
        in_b      = b;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!expect_out) return;
        if (use_exp) begin
            e.res = x_res;
            e.ill = x_ill;
            e.lat = x_lat;
        end else begin
            model(f3, a, b, e.res, e.ill, e.lat);
        end
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        if (hold > 0) begin
            n = 0;
            @(negedge clk);
            #2;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                #2;
                n++;
            end
            if (!out_valid) begin
                fail_now("out_valid_timeout");
                out_ready = 1'b1;
                return;
            end
            for (int i = 0; i < hold; i++) begin
                check("in_ready_while_held", 32'(in_ready), 32'h0);
                check("valid_while_held", 32'(out_valid), 32'h1);
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            #2;
            check("in_ready_after_release", 32'(in_ready), 32'h1);
        end else begin
            n = 0;
            while (done_cnt == d0 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (done_cnt == d0) fail_now("result_timeout");
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        check("reset_in_ready", 32'(in_ready), 32'h1);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_result", out_result, 32'h0);
        check("reset_out_illegal", 32'(out_illegal), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b000, 32'd7, 32'd6, 1, 0, 1, 32'd42, 0, 33);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1, 0, 1, 32'h4000_0000, 0, 33);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 32'hFFFF_FFFE, 0, 33);
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 1, 0, 1, 32'hFFFF_FFFF, 0, 33);
`ifdef MDU_DIV_EN
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1, 0, 1, 32'hFFFF_FFFD, 0, 33);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1, 0, 1, 32'hFFFF_FFFF, 0, 33);
        run_op(3'b101, 32'd100, 32'd0, 1, 0, 1, 32'hFFFF_FFFF, 0, 1);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1, 32'h0, 0, 1);
        run_op(3'b101, 32'd20, 32'd3, 1, 5, 1, 32'd6, 0, 33);
`else
        run_op(3'b100, 32'd10, 32'd2, 1, 0, 1, 32'h0, 1, 1);
        run_op(3'b000, 32'd5, 32'd5, 1, 0, 1, 32'd25, 0, 33);
        run_op(3'b000, 32'd20, 32'd3, 1, 5, 1, 32'd60, 0, 33);
`endif

        // Kill a MUL on its tenth step; nothing may come out of it.
        run_op(3'b000, 32'd1234, 32'd5678, 0, 0, 0, '0, 0, 0);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        #2;
        check("kill_in_ready", 32'(in_ready), 32'h1);
        check("kill_out_valid", 32'(out_valid), 32'h0);
        repeat (40) @(negedge clk);
        run_op(3'b000, 32'd3, 32'd3, 1, 0, 1, 32'd9, 0, 33);

        // Reset in the middle of a busy MULHU.
        run_op(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 0, '0, 0, 0);
        repeat (5) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", 32'(in_ready), 32'h1);
        check("midreset_out_valid", 32'(out_valid), 32'h0);
        check("midreset_out_result", out_result, 32'h0);
        check("midreset_out_illegal", 32'(out_illegal), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1, $urandom_range(0, 2), 0, '0, 0, 0);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits; legal values 8..64, even.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 in_funct3  input  3  RV M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 in_a  input  XLEN  operand rs1.
REQ-008 in_b  input  XLEN  operand rs2.
REQ-009 kill  input  1  abort any in-flight operation.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out_result  output  XLEN  result.
REQ-013 out_illegal  output  1  op not supported in this build; qualified by out_valid.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-015 Accept = in_valid && in_ready at a rising edge; operands and funct3 are captured; signed operands are converted to magnitudes and the result sign is recorded.
REQ-016 Normal ops SHALL go IDLE->BUSY, perform one shift-add (mul) or restoring shift-subtract (div) step per cycle for exactly XLEN cycles, then enter DONE; out_valid rises XLEN+1 cycles after the accept edge.
REQ-017 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU the high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-018 Divide by zero SHALL take a fast path (IDLE->DONE, out_valid on the cycle after accept): quotient all ones, remainder = in_a, for signed and unsigned.
REQ-019 Signed overflow (in_a = most-negative, in_b = -1, DIV/REM) SHALL take the fast path: quotient = in_a, remainder = 0.
REQ-020 Signed quotient SHALL be truncated toward zero; remainder sign SHALL equal dividend sign.
REQ-021 In DONE, out_valid, out_result and out_illegal SHALL hold stable until out_ready; on out_valid && out_ready the FSM returns to IDLE (no accept in the same cycle).
REQ-022 kill SHALL force IDLE at the next edge from any state, drop out_valid, and block accept in that cycle; kill has priority over out_ready and accept.
REQ-023 out_result SHALL be 0 whenever out_valid = 0.

Reset
REQ-024 On rst_n low, state = IDLE, in_ready = 1, out_valid = 0, out_result = 0, out_illegal = 0, step counter = 0, immediately and independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard the operation with no result produced.

Configuration
REQ-026 Macro MDU_DIV_EN: defined -> divide/remainder datapath built, ops 100-111 behave per REQ-016..020.
REQ-027 MDU_DIV_EN undefined -> no divider logic; ops 100-111 take the fast path with out_result = 0, out_illegal = 1; multiply ops unchanged; out_illegal is always 0 for ops 000-011.

Structure
REQ-028 Package alu_mdu_pkg SHALL hold funct3 op constants, the FSM state typedef and a helper constant for counter width ($clog2(XLEN)+1).
REQ-029 Single module; no sub-module: mul and div SHALL share one 2*XLEN shift register and one XLEN+1 adder/subtractor.

Verification
REQ-030 XLEN=32, MUL 7 x 6 -> out_valid exactly 33 cycles after accept, out_result = 42, out_illegal = 0.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 0 -> 0xFFFFFFFF after 1 cycle; REM 0x80000000 / -1 -> 0 after 1 cycle.
REQ-033 Hold out_ready = 0 for 5 cycles after a DIVU 20/3 -> out_valid and out_result = 6 stable, in_ready = 0 throughout; release -> in_ready = 1 next cycle.
REQ-034 kill at cycle 10 of a MUL -> IDLE next edge, out_valid never asserts; new MUL 3 x 3 then returns 9; rst_n low mid-BUSY -> all outputs per REQ-024 immediately.
REQ-035 Build without MDU_DIV_EN: DIV 10 / 2 -> out_valid next cycle, out_result = 0, out_illegal = 1; MUL 5 x 5 -> 25, out_illegal = 0.
